div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle controller plus radix-2 restoring-divide datapath for the MIPS DIV/DIVU instructions.
- Sits beside the execute-stage ALU. It is started by the decoded mul/div class, stalls the pipeline through the hazard unit while iterating, and returns the HI (remainder) and LO (quotient) pair for the HILO write.
- Supports cancellation on pipeline flush.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start_i  input  1  execute-stage instruction is DIV/DIVU; held high while the instruction sits in E.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- a_i  input  WIDTH  dividend (rs), sampled on start acceptance.
- b_i  input  WIDTH  divisor (rt), sampled on start acceptance.
- cancel_i  input  1  flushE; aborts any operation in progress.
- hold_i  input  1  external stall of E from another hazard source; holds completed result.
- stall_o  output  1  request to hazard unit to stall F/D/E.
- ready_o  output  1  result valid; E may advance.
- busy_o  output  1  operation in progress (BUSY state).
- divzero_o  output  1  divisor was zero; valid with ready_o.
- hi_o  output  WIDTH  remainder; valid with ready_o.
- lo_o  output  WIDTH  quotient; valid with ready_o.

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, all internal registers and all outputs 0.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY when start_i=1 and cancel_i=0.
  - Latch |a_i| and |b_i| (absolute value only when signed_i=1 and the MSB is set).
  - Latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB] (both forced 0 when signed_i=0).
  - Latch divzero = (b_i==0); clear partial remainder; count=0.
- BUSY, one iteration per cycle:
  - Shift {rem,quo} left 1.
  - Trial-subtract the divisor on WIDTH+1 bits; if non-negative, keep the difference and set quo[0]=1.
  - count increments. When count==WIDTH-1 the next state is DONE. BUSY lasts exactly WIDTH cycles.
- DONE:
  - Registered outputs are applied on entry: lo_o = sign_q ? -quo : quo; hi_o = sign_r ? -rem : rem.
  - Divide-by-zero overrides these: lo_o = all ones, hi_o = latched dividend a (raw, pre-abs); divzero_o=1.
  - ready_o=1. Stay in DONE while hold_i=1; go to IDLE when hold_i=0.
- stall_o = start_i & ~ready_o (combinational). This covers the IDLE acceptance cycle and all BUSY cycles, and drops in DONE.
- Latency: start seen in cycle T0 (IDLE), BUSY T1..T32, DONE at T33. stall_o is high for 33 cycles when WIDTH=32.
- The IDLE cycle after DONE may accept a new start_i, so back-to-back divides are allowed. A single instruction is never re-executed, because DONE persists under hold_i.
- cancel_i in any state: next state IDLE, ready_o=0, busy_o=0. hi_o and lo_o keep their last values. It has priority over start_i and over the transition to DONE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This is natural wrap with no trap.
- ready_o, busy_o, divzero_o, hi_o and lo_o are registered. Only stall_o is combinational.
- Reset asserted mid-BUSY returns to IDLE immediately, with outputs cleared.

Test Plan:
- DIVU a=100, b=7: stall_o high T0..T32, ready_o at T33 with lo=14, hi=2, divzero_o=0.
- DIV a=-7 (0xFFFFFFF9), b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 7/-2 gives lo=-3, hi=1.
- DIVU a=0x12345678, b=0: ready at T33, divzero_o=1, lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- cancel_i pulsed at T10 of BUSY: IDLE next cycle, no ready_o pulse, stall_o tracks start_i. A fresh start then completes normally 33 cycles later.
- hold_i=1 for 5 cycles at DONE: ready_o stays high for 6 cycles with a stable result, and no restart occurs. A back-to-back second DIVU 9/3 is accepted in the following IDLE cycle and gives lo=3, hi=0.
- rst driven low asynchronously mid-BUSY (between clock edges): all outputs are 0 immediately. After release with start_i=1, operation proceeds from IDLE.

Source files
------------

// File: rtl/div_sequencer_if.sv
// Handshake and operand/result bundle between the execute stage and the divider.
// master = pipeline side, slave = divider side.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cancel_i;
    logic             hold_i;
    logic             stall_o;
    logic             ready_o;
    logic             busy_o;
    logic             divzero_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, signed_i, a_i, b_i, cancel_i, hold_i,
        input  stall_o, ready_o, busy_o, divzero_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, signed_i, a_i, b_i, cancel_i, hold_i,
        output stall_o, ready_o, busy_o, divzero_o, hi_o, lo_o
    );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring DIV/DIVU sequencer: start in IDLE, WIDTH BUSY cycles, result registered on DONE entry.
// Stalls F/D/E while start_i is high and no result is ready; DONE holds the result while hold_i is high.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    div_sequencer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic             sgn_quo_q, sgn_quo_d;
    logic             sgn_rem_q, sgn_rem_d;
    logic             dz_q, dz_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             dzo_q, dzo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_it;
    logic [WIDTH-1:0] quo_it;
    logic             neg_a;
    logic             neg_b;

    // One restoring step: shift {rem,quo}, trial-subtract on WIDTH+1 bits so the
    // carry out of the shifted remainder is never lost for large divisors.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, div_q};
        if (!trial[WIDTH]) begin
            rem_it = trial[WIDTH-1:0];
            quo_it = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_it = rem_sh[WIDTH-1:0];
            quo_it = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    assign neg_a = bus.signed_i & bus.a_i[WIDTH-1];
    assign neg_b = bus.signed_i & bus.b_i[WIDTH-1];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        araw_d    = araw_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        dz_d      = dz_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        dzo_d     = dzo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                busy_d  = 1'b0;
                dzo_d   = 1'b0;
                if (bus.start_i && !bus.cancel_i) begin
                    state_d   = BUSY;
                    busy_d    = 1'b1;
                    quo_d     = neg_a ? -bus.a_i : bus.a_i;
                    div_d     = neg_b ? -bus.b_i : bus.b_i;
                    araw_d    = bus.a_i;
                    sgn_quo_d = neg_a ^ neg_b;
                    sgn_rem_d = neg_a;
                    dz_d      = (bus.b_i == '0);
                    rem_d     = '0;
                    count_d   = '0;
                end
            end
            BUSY: begin
                rem_d   = rem_it;
                quo_d   = quo_it;
                count_d = count_q + 1'b1;
                busy_d  = 1'b1;
                if (count_q == LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    dzo_d   = dz_q;
                    // Divide-by-zero reports all-ones quotient and the untouched dividend.
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = araw_q;
                    end else begin
                        lo_d = sgn_quo_q ? -quo_it : quo_it;
                        hi_d = sgn_rem_q ? -rem_it : rem_it;
                    end
                end
            end
            DONE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (!bus.hold_i) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                    dzo_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
                busy_d  = 1'b0;
                dzo_d   = 1'b0;
            end
        endcase

        // Flush wins over acceptance and completion; the last result stays visible.
        if (bus.cancel_i) begin
            state_d = IDLE;
            ready_d = 1'b0;
            busy_d  = 1'b0;
            dzo_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            araw_q    <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            dzo_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            araw_q    <= araw_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            dz_q      <= dz_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            dzo_q     <= dzo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.stall_o   = bus.start_i & ~ready_q;
    assign bus.ready_o   = ready_q;
    assign bus.busy_o    = busy_q;
    assign bus.divzero_o = dzo_q;
    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboarded bench for div_sequencer: directed corner cases plus random DIV/DIVU traffic.
module tb_div_sequencer;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;

    always #5 clk = ~clk;

    div_sequencer_if #(.WIDTH(W)) bus ();
    div_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Truncating division done in 64-bit arithmetic, so the signed overflow case is exact.
    function automatic exp_t model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sb, q, r;
        if (b == '0) begin
            e.lo = '1;
            e.hi = a;
            e.dz = 1'b1;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            e.lo = q[W-1:0];
            e.hi = r[W-1:0];
            e.dz = 1'b0;
        end else begin
            e.lo = a / b;
            e.hi = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst && bus.ready_o) begin
            if (sbq.size() == 0) begin
                check("spurious_ready", {63'd0, bus.ready_o}, 64'd0);
            end else begin
                check("lo", {32'd0, bus.lo_o}, {32'd0, sbq[0].lo});
                check("hi", {32'd0, bus.hi_o}, {32'd0, sbq[0].hi});
                check("divzero", {63'd0, bus.divzero_o}, {63'd0, sbq[0].dz});
                if (!bus.hold_i) sbq.delete(0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold_n, input int cancel_at, input bit rst_mid);
        exp_t e;
        int   cyc;
        int   stl;
        int   rdy_cnt;
        bit   done;
        e = model(sg, a, b);
        if (cancel_at < 0 && !rst_mid) sbq.push_back(e);
        check("idle_ready", {63'd0, bus.ready_o}, 64'd0);
        check("idle_busy", {63'd0, bus.busy_o}, 64'd0);
        bus.start_i  = 1'b1;
        bus.signed_i = sg;
        bus.a_i      = a;
        bus.b_i      = b;
        cyc  = 0;
        stl  = 0;
        done = 1'b0;
        while (!done) begin
            #1;
            if (bus.ready_o) begin
                done = 1'b1;
            end else begin
                if (bus.stall_o) stl++;
                if (cyc == cancel_at) begin
                    bus.cancel_i = 1'b1;
                    #1;
                    check("cancel_stall", {63'd0, bus.stall_o}, 64'd1);
                    tick();
                    bus.cancel_i = 1'b0;
                    bus.start_i  = 1'b0;
                    #1;
                    check("cancel_busy", {63'd0, bus.busy_o}, 64'd0);
                    check("cancel_ready", {63'd0, bus.ready_o}, 64'd0);
                    check("cancel_stall_drop", {63'd0, bus.stall_o}, 64'd0);
                    check("cancel_keep_lo", {32'd0, bus.lo_o}, {32'd0, last_lo});
                    check("cancel_keep_hi", {32'd0, bus.hi_o}, {32'd0, last_hi});
                    repeat (3) tick();
                    return;
                end
                if (rst_mid && cyc == 12) begin
                    #1;
                    rst = 1'b0;
                    #1;
                    check("rst_ready", {63'd0, bus.ready_o}, 64'd0);
                    check("rst_busy", {63'd0, bus.busy_o}, 64'd0);
                    check("rst_divzero", {63'd0, bus.divzero_o}, 64'd0);
                    check("rst_lo", {32'd0, bus.lo_o}, 64'd0);
                    check("rst_hi", {32'd0, bus.hi_o}, 64'd0);
                    last_lo = '0;
                    last_hi = '0;
                    repeat (2) tick();
                    rst = 1'b1;
                    return;
                end
                if (cyc >= 100) begin
                    check("ready_timeout", {63'd0, bus.ready_o}, 64'd1);
                    bus.start_i = 1'b0;
                    return;
                end
                tick();
                cyc++;
            end
        end
        check("latency", 64'(cyc), 64'(W + 1));
        check("stall_cycles", 64'(stl), 64'(W + 1));
        check("done_stall", {63'd0, bus.stall_o}, 64'd0);
        check("done_busy", {63'd0, bus.busy_o}, 64'd0);
        rdy_cnt = 1;
        for (int i = 0; i < hold_n; i++) begin
            bus.hold_i = 1'b1;
            tick();
            #1;
            if (bus.ready_o) rdy_cnt++;
            check("hold_stall", {63'd0, bus.stall_o}, 64'd0);
            check("hold_busy", {63'd0, bus.busy_o}, 64'd0);
        end
        check("ready_len", 64'(rdy_cnt), 64'(hold_n + 1));
        bus.hold_i  = 1'b0;
        bus.start_i = 1'b0;
        last_lo = e.lo;
        last_hi = e.hi;
        tick();
    endtask

    initial begin
        bus.start_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.a_i      = '0;
        bus.b_i      = '0;
        bus.cancel_i = 1'b0;
        bus.hold_i   = 1'b0;
        #3;
        check("reset_ready", {63'd0, bus.ready_o}, 64'd0);
        check("reset_busy", {63'd0, bus.busy_o}, 64'd0);
        check("reset_stall", {63'd0, bus.stall_o}, 64'd0);
        check("reset_lo", {32'd0, bus.lo_o}, 64'd0);
        check("reset_hi", {32'd0, bus.hi_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        run_op(1'b0, 32'd100, 32'd7, 0, -1, 1'b0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, -1, 1'b0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, -1, 1'b0);
        run_op(1'b0, 32'h1234_5678, 32'd0, 0, -1, 1'b0);
        run_op(1'b1, 32'hFFFF_FF00, 32'd0, 1, -1, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0, -1, 1'b0);
        run_op(1'b0, 32'd1000, 32'd3, 0, 10, 1'b0);
        run_op(1'b0, 32'd1000, 32'd3, 0, -1, 1'b0);
        run_op(1'b0, 32'd50, 32'd5, 5, -1, 1'b0);
        run_op(1'b0, 32'd9, 32'd3, 0, -1, 1'b0);
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 0, -1, 1'b1);
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 0, -1, 1'b0);

        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = W'($urandom_range(1, 15));
                1: rb = (k % 6 == 0) ? '0 : W'($urandom);
                2: rb = -W'($urandom_range(1, 300));
                default: rb = W'($urandom);
            endcase
            run_op(1'($urandom_range(0, 1)), ra, rb, int'($urandom_range(0, 3)), -1, 1'b0);
        end

        repeat (3) tick();
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
